// File: rtl/global_defs.sv
// Shared types for the misprediction recovery sequencer.
// ROB_ID_WIDTH falls back to 4 bits when the build does not define it.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif

package global_defs;

  // Tag and PC types shared with the dispatch stage
  typedef logic [`ROB_ID_WIDTH-1:0] rob_id_t;
  typedef logic [31:0]              addr_t;

  // Recovery sequence phases
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HEAD = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_REDIRECT  = 3'd4
  } recovery_state_t;

endpackage

// File: rtl/rob_age_cmp.sv
// Modular ROB age comparator: a_older_o is high when tag a is strictly
// older than tag b, where age is the tag's distance ahead of the head,
// taken modulo 2^W (no sign extension).
module rob_age_cmp #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] head_i,
  output logic         a_older_o
);

  logic [W-1:0] age_a_s;
  logic [W-1:0] age_b_s;

  // Distance of each tag from the head, wrapped to W bits, then compared
  always_comb begin
    age_a_s   = a_i - head_i;
    age_b_s   = b_i - head_i;
    a_older_o = (age_a_s < age_b_s);
  end

endmodule

// File: rtl/recovery_ctrl.sv
// recovery_ctrl: captures the oldest ALU/LSU misprediction, waits for it to
// retire, pulses flush, clears the alias table entry by entry, then
// redirects fetch. Dispatch is stalled for the whole sequence.
// Optional feature: define RECOVERY_CNT_EN to add the recovery_cnt port
// counting completed recoveries.
module recovery_ctrl
  import global_defs::*;
#(
  parameter int unsigned N_ARF_ENTRIES = 32,
  parameter int unsigned ROB_ID_WIDTH  = `ROB_ID_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_aH,
  input  logic                             alu_broadcast_valid,
  input  logic [ROB_ID_WIDTH-1:0]          alu_broadcast_rob_id,
  input  logic                             alu_br_mispred,
  input  logic [31:0]                      alu_br_target,
  input  logic                             ld_broadcast_valid,
  input  logic [ROB_ID_WIDTH-1:0]          ld_broadcast_rob_id,
  input  logic                             ld_mispred,
  input  logic [31:0]                      ld_replay_pc,
  input  logic [ROB_ID_WIDTH-1:0]          rob_head_rob_id,
  input  logic                             rob_retire,
  output logic                             dispatch_stall,
  output logic                             flush,
  output logic                             rat_clr_en,
  output logic [$clog2(N_ARF_ENTRIES)-1:0] rat_clr_addr,
  output logic                             fetch_redirect_valid,
  output logic [31:0]                      fetch_redirect_pc,
  input  logic                             fetch_redirect_ready,
  output logic                             busy
`ifdef RECOVERY_CNT_EN
  ,
  output logic [31:0]                      recovery_cnt
`endif
);

  localparam int unsigned CLR_W = $clog2(N_ARF_ENTRIES);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(N_ARF_ENTRIES - 1);

  recovery_state_t         state_q, state_d;
  logic [ROB_ID_WIDTH-1:0] tag_q, tag_d;
  addr_t                   tgt_q, tgt_d;
  logic [CLR_W-1:0]        cnt_q, cnt_d;

  logic                    flush_q;
  logic                    clr_en_q;
  logic [CLR_W-1:0]        clr_addr_q;
  logic                    rv_q;
  addr_t                   rpc_q;
  logic                    busy_q;

  logic                    alu_ev_s;
  logic                    ld_ev_s;
  logic                    cand_ev_s;
  logic [ROB_ID_WIDTH-1:0] cand_tag_s;
  addr_t                   cand_tgt_s;
  logic                    ld_older_s;
  logic                    cand_older_s;

  // LSU strictly older than ALU; on equal age the ALU event is kept
  rob_age_cmp #(.W(ROB_ID_WIDTH)) u_cmp_src (
    .a_i       (ld_broadcast_rob_id),
    .b_i       (alu_broadcast_rob_id),
    .head_i    (rob_head_rob_id),
    .a_older_o (ld_older_s)
  );

  // New candidate strictly older than the one already latched
  rob_age_cmp #(.W(ROB_ID_WIDTH)) u_cmp_latched (
    .a_i       (cand_tag_s),
    .b_i       (tag_q),
    .head_i    (rob_head_rob_id),
    .a_older_o (cand_older_s)
  );

  // Qualify this cycle's mispredicts and pick the older as the candidate
  always_comb begin
    alu_ev_s  = alu_broadcast_valid & alu_br_mispred;
    ld_ev_s   = ld_broadcast_valid & ld_mispred;
    cand_ev_s = alu_ev_s | ld_ev_s;
    if (ld_ev_s && (!alu_ev_s || ld_older_s)) begin
      cand_tag_s = ld_broadcast_rob_id;
      cand_tgt_s = ld_replay_pc;
    end else begin
      cand_tag_s = alu_broadcast_rob_id;
      cand_tgt_s = alu_br_target;
    end
  end

  // Next-state logic for the recovery sequence and its latched data
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_ev_s) begin
          state_d = ST_WAIT_HEAD;
          tag_d   = cand_tag_s;
          tgt_d   = cand_tgt_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_HEAD: begin
        // A matching retire takes priority; a same-cycle event is dropped
        if (rob_retire && (rob_head_rob_id == tag_q)) begin
          state_d = ST_FLUSH;
        end else if (cand_ev_s && cand_older_s) begin
          tag_d = cand_tag_s;
          tgt_d = cand_tgt_s;
        end else begin
          state_d = ST_WAIT_HEAD;
        end
      end
      ST_FLUSH: begin
        cnt_d   = '0;
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Hold on the last address rather than wrapping
        if (cnt_q == CLR_LAST) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q + CLR_W'(1);
        end
      end
      ST_REDIRECT: begin
        if (fetch_redirect_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched tag/target/counter registers
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      tgt_q   <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output flops decoded from the next state so every output is registered
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      flush_q    <= 1'b0;
      clr_en_q   <= 1'b0;
      clr_addr_q <= '0;
      rv_q       <= 1'b0;
      rpc_q      <= 32'd0;
      busy_q     <= 1'b0;
    end else begin
      flush_q    <= (state_d == ST_FLUSH);
      clr_en_q   <= (state_d == ST_CLEAR);
      clr_addr_q <= (state_d == ST_CLEAR) ? cnt_d : '0;
      rv_q       <= (state_d == ST_REDIRECT);
      rpc_q      <= (state_d == ST_REDIRECT) ? tgt_d : 32'd0;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign flush                = flush_q;
  assign rat_clr_en           = clr_en_q;
  assign rat_clr_addr         = clr_addr_q;
  assign fetch_redirect_valid = rv_q;
  assign fetch_redirect_pc    = rpc_q;
  assign busy                 = busy_q;
  assign dispatch_stall       = busy_q;

`ifdef RECOVERY_CNT_EN
  logic [31:0] rec_cnt_q;

  // Count completed recoveries (REDIRECT accepted by fetch), wrapping at 2^32
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      rec_cnt_q <= 32'd0;
    end else if ((state_q == ST_REDIRECT) && fetch_redirect_ready) begin
      rec_cnt_q <= rec_cnt_q + 32'd1;
    end else begin
      rec_cnt_q <= rec_cnt_q;
    end
  end

  assign recovery_cnt = rec_cnt_q;
`endif

endmodule

// File: tb/tb_recovery_ctrl.sv
// Self-checking bench for recovery_ctrl: directed scenarios with literal
// expectations plus a cycle-phase model checked on every falling edge.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif

module tb_recovery_ctrl;

  localparam int W  = `ROB_ID_WIDTH;
  localparam int N  = 32;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_aH = 1'b1;
  logic          alu_broadcast_valid = 1'b0;
  logic [W-1:0]  alu_broadcast_rob_id = '0;
  logic          alu_br_mispred = 1'b0;
  logic [31:0]   alu_br_target = 32'd0;
  logic          ld_broadcast_valid = 1'b0;
  logic [W-1:0]  ld_broadcast_rob_id = '0;
  logic          ld_mispred = 1'b0;
  logic [31:0]   ld_replay_pc = 32'd0;
  logic [W-1:0]  rob_head_rob_id = '0;
  logic          rob_retire = 1'b0;
  logic          fetch_redirect_ready = 1'b1;
  logic          dispatch_stall;
  logic          flush;
  logic          rat_clr_en;
  logic [AW-1:0] rat_clr_addr;
  logic          fetch_redirect_valid;
  logic [31:0]   fetch_redirect_pc;
  logic          busy;
`ifdef RECOVERY_CNT_EN
  logic [31:0]   recovery_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  recovery_ctrl #(.N_ARF_ENTRIES(N), .ROB_ID_WIDTH(W)) dut (
    .clk                  (clk),
    .rst_aH               (rst_aH),
    .alu_broadcast_valid  (alu_broadcast_valid),
    .alu_broadcast_rob_id (alu_broadcast_rob_id),
    .alu_br_mispred       (alu_br_mispred),
    .alu_br_target        (alu_br_target),
    .ld_broadcast_valid   (ld_broadcast_valid),
    .ld_broadcast_rob_id  (ld_broadcast_rob_id),
    .ld_mispred           (ld_mispred),
    .ld_replay_pc         (ld_replay_pc),
    .rob_head_rob_id      (rob_head_rob_id),
    .rob_retire           (rob_retire),
    .dispatch_stall       (dispatch_stall),
    .flush                (flush),
    .rat_clr_en           (rat_clr_en),
    .rat_clr_addr         (rat_clr_addr),
    .fetch_redirect_valid (fetch_redirect_valid),
    .fetch_redirect_pc    (fetch_redirect_pc),
    .fetch_redirect_ready (fetch_redirect_ready),
    .busy                 (busy)
`ifdef RECOVERY_CNT_EN
    ,
    .recovery_cnt         (recovery_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Age as plain integer distance from head modulo 2^W.
  function automatic int age(input int t, input int h);
    return (((t - h) % (1 << W)) + (1 << W)) % (1 << W);
  endfunction

  // Model: m_k = cycles since the matching retire (0 while waiting).
  bit          m_busy = 1'b0;
  int          m_k    = 0;
  int          m_tag  = 0;
  logic [31:0] m_tgt  = 32'd0;
  logic [31:0] m_cnt  = 32'd0;

  bit          c_any;
  int          c_tag;
  logic [31:0] c_tgt;

  always_comb begin
    c_any = 1'b0;
    c_tag = 0;
    c_tgt = 32'd0;
    if ((ld_broadcast_valid && ld_mispred) &&
        !((alu_broadcast_valid && alu_br_mispred) &&
          age(int'(alu_broadcast_rob_id), int'(rob_head_rob_id)) <=
          age(int'(ld_broadcast_rob_id), int'(rob_head_rob_id)))) begin
      c_any = 1'b1;
      c_tag = int'(ld_broadcast_rob_id);
      c_tgt = ld_replay_pc;
    end else if (alu_broadcast_valid && alu_br_mispred) begin
      c_any = 1'b1;
      c_tag = int'(alu_broadcast_rob_id);
      c_tgt = alu_br_target;
    end
  end

  always @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_tag  <= 0;
      m_tgt  <= 32'd0;
      m_cnt  <= 32'd0;
    end else if (!m_busy) begin
      if (c_any) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_tag  <= c_tag;
        m_tgt  <= c_tgt;
      end
    end else if (m_k == 0) begin
      if (rob_retire && int'(rob_head_rob_id) == m_tag) begin
        m_k <= 1;
      end else if (c_any && age(c_tag, int'(rob_head_rob_id)) < age(m_tag, int'(rob_head_rob_id))) begin
        m_tag <= c_tag;
        m_tgt <= c_tgt;
      end
    end else if (m_k >= N + 2) begin
      if (fetch_redirect_ready) begin
        m_busy <= 1'b0;
        m_k    <= 0;
        m_cnt  <= m_cnt + 32'd1;
      end
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Compare DUT outputs against the model every falling edge
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("dispatch_stall", 32'(dispatch_stall), 32'(m_busy));
    check("flush", 32'(flush), 32'(m_busy && m_k == 1));
    check("rat_clr_en", 32'(rat_clr_en), 32'(m_busy && m_k >= 2 && m_k <= N + 1));
    if (m_busy && m_k >= 2 && m_k <= N + 1)
      check("rat_clr_addr", 32'(rat_clr_addr), 32'(m_k - 2));
    check("redirect_valid", 32'(fetch_redirect_valid), 32'(m_busy && m_k >= N + 2));
    if (m_busy && m_k >= N + 2)
      check("redirect_pc", fetch_redirect_pc, m_tgt);
`ifdef RECOVERY_CNT_EN
    check("recovery_cnt", recovery_cnt, m_cnt);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic alu_event(input int tag, input logic [31:0] tgt);
    alu_broadcast_valid  = 1'b1;
    alu_br_mispred       = 1'b1;
    alu_broadcast_rob_id = W'(tag);
    alu_br_target        = tgt;
    tick();
    alu_broadcast_valid  = 1'b0;
    alu_br_mispred       = 1'b0;
  endtask

  task automatic both_events(input int atag, input logic [31:0] atgt,
                             input int ltag, input logic [31:0] lpc);
    alu_broadcast_valid  = 1'b1;
    alu_br_mispred       = 1'b1;
    alu_broadcast_rob_id = W'(atag);
    alu_br_target        = atgt;
    ld_broadcast_valid   = 1'b1;
    ld_mispred           = 1'b1;
    ld_broadcast_rob_id  = W'(ltag);
    ld_replay_pc         = lpc;
    tick();
    alu_broadcast_valid  = 1'b0;
    alu_br_mispred       = 1'b0;
    ld_broadcast_valid   = 1'b0;
    ld_mispred           = 1'b0;
  endtask

  task automatic retire(input int tag);
    rob_head_rob_id = W'(tag);
    rob_retire      = 1'b1;
    tick();
    rob_retire      = 1'b0;
  endtask

  task automatic wait_rv(input string name);
    for (int i = 0; i < 100 && !fetch_redirect_valid; i++) tick();
    check(name, 32'(fetch_redirect_valid), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_clr_en", 32'(rat_clr_en), 32'd0);
    check("rst_rv", 32'(fetch_redirect_valid), 32'd0);
    check("rst_pc", fetch_redirect_pc, 32'd0);
    rst_aH = 1'b0;
    tick();

    // ALU mispredict: tag 5, head 3, target 0x1000
    rob_head_rob_id = W'(3);
    alu_event(5, 32'h1000);
    check("t1_busy_next", 32'(busy), 32'd1);
    repeat (4) tick();
    retire(5);
    check("t1_flush", 32'(flush), 32'd1);
    for (int i = 0; i < N; i++) begin
      tick();
      check("t1_clr_en", 32'(rat_clr_en), 32'd1);
      check("t1_clr_addr", 32'(rat_clr_addr), 32'(i));
    end
    tick();
    check("t1_rv", 32'(fetch_redirect_valid), 32'd1);
    check("t1_pc", fetch_redirect_pc, 32'h1000);
    tick();
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_stall_off", 32'(dispatch_stall), 32'd0);

    // Simultaneous: head 14, ALU tag 2 (age 4) vs LSU tag 15 (age 1)
    tick();
    rob_head_rob_id = W'(14);
    both_events(2, 32'hA000, 15, 32'hB000);
    retire(2);
    check("t2_no_flush", 32'(flush), 32'd0);
    tick();
    retire(15);
    check("t2_flush", 32'(flush), 32'd1);
    repeat (3) tick();
    alu_event(3, 32'hDEAD);            // arrives during CLEAR; must be ignored
    wait_rv("t2_wait_rv");
    check("t2_pc", fetch_redirect_pc, 32'hB000);
    tick();
    check("t2_idle", 32'(busy), 32'd0);

    // Equal age: ALU wins
    rob_head_rob_id = W'(0);
    both_events(4, 32'h4444, 4, 32'h5555);
    retire(4);
    wait_rv("t2b_wait_rv");
    check("t2b_pc", fetch_redirect_pc, 32'h4444);
    tick();

    // Older event replaces: latched 9, new 7, head 6
    rob_head_rob_id = W'(6);
    alu_event(9, 32'h9000);
    alu_event(7, 32'h7000);
    retire(9);
    check("t3_no_flush", 32'(flush), 32'd0);
    tick();
    check("t3_still_busy", 32'(busy), 32'd1);
    retire(7);
    check("t3_flush", 32'(flush), 32'd1);
    wait_rv("t3_wait_rv");
    check("t3_pc", fetch_redirect_pc, 32'h7000);
    tick();

    // Redirect backpressure: ready low 5 cycles
    fetch_redirect_ready = 1'b0;
    rob_head_rob_id = W'(1);
    alu_event(2, 32'h2222);
    retire(2);
    wait_rv("t4_wait_rv");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_rv_held", 32'(fetch_redirect_valid), 32'd1);
      check("t4_pc_held", fetch_redirect_pc, 32'h2222);
    end
    fetch_redirect_ready = 1'b1;
    tick();
    check("t4_idle", 32'(busy), 32'd0);

    // Reset during CLEAR at address 12
    rob_head_rob_id = W'(3);
    alu_event(4, 32'h4040);
    retire(4);
    for (int i = 0; i < 60 && !(rat_clr_en && rat_clr_addr == AW'(12)); i++) tick();
    check("t5_at_12", 32'(rat_clr_addr), 32'd12);
    rst_aH = 1'b1;
    #1;
    check("t5_busy0", 32'(busy), 32'd0);
    check("t5_clr0", 32'(rat_clr_en), 32'd0);
    check("t5_flush0", 32'(flush), 32'd0);
    check("t5_rv0", 32'(fetch_redirect_valid), 32'd0);
    tick();
    tick();
    rst_aH = 1'b0;
    repeat (50) tick();
    check("t5_no_redirect", 32'(fetch_redirect_valid), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);

    // Three completed recoveries after reset
    for (int k = 0; k < 3; k++) begin
      rob_head_rob_id = W'(k);
      alu_event(k + 1, 32'h100 * k);
      retire(k + 1);
      wait_rv("t6_wait_rv");
      tick();
    end
    check("t6_idle", 32'(busy), 32'd0);
`ifdef RECOVERY_CNT_EN
    check("t6_cnt", recovery_cnt, 32'd3);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
